// File: rtl/branch_unit_pkg.sv
// Shared bexkat definitions used by the branch unit and its condition evaluator.
// Holds the branch condition encoding, the CCR flag bit positions (matching the
// ALU {c,z,n,v} packing) and the branch unit's state encoding.
package bexkat1Def;

   // Branch / conditional-set condition codes.
   typedef enum logic [3:0] {
      BRA  = 4'd0,
      BRN  = 4'd1,
      BEQ  = 4'd2,
      BNE  = 4'd3,
      BLTU = 4'd4,
      BGEU = 4'd5,
      BGTU = 4'd6,
      BLEU = 4'd7,
      BLT  = 4'd8,
      BGE  = 4'd9,
      BGT  = 4'd10,
      BLE  = 4'd11,
      BMI  = 4'd12,
      BPL  = 4'd13,
      BVS  = 4'd14,
      BVC  = 4'd15
   } cond_t;

   // Flag positions inside the 4-bit CCR, {C,Z,N,V} from MSB to LSB.
   localparam int CCR_C = 3;
   localparam int CCR_Z = 2;
   localparam int CCR_N = 1;
   localparam int CCR_V = 0;

   // Branch unit control states.
   typedef enum logic [1:0] {
      BR_IDLE = 2'd0,
      BR_HOLD = 2'd1,
      BR_RESP = 2'd2
   } br_state_t;

   // Cycles a held branch waits for an older flag update to land in the CCR.
   localparam logic [1:0] WAIT_SETCC = 2'd2;
   localparam logic [1:0] WAIT_PEND  = 2'd1;

   // Pack individual ALU flags into CCR order.
   function automatic logic [3:0] pack_flags(input logic c, input logic z,
                                             input logic n, input logic v);
      logic [3:0] f;
      f        = 4'b0000;
      f[CCR_C] = c;
      f[CCR_Z] = z;
      f[CCR_N] = n;
      f[CCR_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/branch_unit_cond.sv
// Combinational condition evaluator: decides whether a condition code holds
// for a given CCR. Shared by branches and conditional-set instructions.
import bexkat1Def::*;

module cond_eval (
   input  logic [3:0] cond,
   input  logic [3:0] ccr,
   output logic       taken
);

   logic c_flag;
   logic z_flag;
   logic n_flag;
   logic v_flag;
   logic signed_lt;

   assign c_flag    = ccr[CCR_C];
   assign z_flag    = ccr[CCR_Z];
   assign n_flag    = ccr[CCR_N];
   assign v_flag    = ccr[CCR_V];
   assign signed_lt = n_flag ^ v_flag;

   // Decode the condition against the flags; C is the ALU carry/borrow as produced.
   always_comb begin
      taken = 1'b0;
      case (cond_t'(cond))
         BRA:     taken = 1'b1;
         BRN:     taken = 1'b0;
         BEQ:     taken = z_flag;
         BNE:     taken = ~z_flag;
         BLTU:    taken = c_flag;
         BGEU:    taken = ~c_flag;
         BGTU:    taken = ~c_flag & ~z_flag;
         BLEU:    taken = c_flag | z_flag;
         BLT:     taken = signed_lt;
         BGE:     taken = ~signed_lt;
         BGT:     taken = ~z_flag & ~signed_lt;
         BLE:     taken = z_flag | signed_lt;
         BMI:     taken = n_flag;
         BPL:     taken = ~n_flag;
         BVS:     taken = v_flag;
         BVC:     taken = ~v_flag;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_unit.sv
// Branch unit for the bexkat2 core. Owns the architectural CCR, loads it from
// the ALU's registered flags, and resolves conditional branches once every
// older flag update has landed. The resolved PC returns over valid/ready.
import bexkat1Def::*;

module branch_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             setcc,
   input  logic             c_in,
   input  logic             z_in,
   input  logic             n_in,
   input  logic             v_in,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [3:0]       br_cond,
   input  logic [WIDTH-1:0] br_target,
   input  logic [WIDTH-1:0] br_next,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_taken,
   output logic [WIDTH-1:0] res_pc,
   output logic [3:0]       ccr_out
);

   br_state_t        state_q,     state_d;
   logic [1:0]       wait_q,      wait_d;
   logic             pend_q,      pend_d;
   logic [3:0]       ccr_q,       ccr_d;
   logic [3:0]       cond_q,      cond_d;
   logic [WIDTH-1:0] target_q,    target_d;
   logic [WIDTH-1:0] next_q,      next_d;
   logic             res_valid_q, res_valid_d;
   logic             res_taken_q, res_taken_d;
   logic [WIDTH-1:0] res_pc_q,    res_pc_d;

   logic             accept;
   logic [3:0]       eval_cond;
   logic [WIDTH-1:0] eval_target;
   logic [WIDTH-1:0] eval_next;
   logic             eval_taken;

   assign br_ready  = rst_i & (state_q == BR_IDLE);
   assign accept    = br_valid & br_ready;
   assign res_valid = res_valid_q;
   assign res_taken = res_taken_q;
   assign res_pc    = res_pc_q;
   assign ccr_out   = ccr_q;

   // In IDLE the branch is evaluated straight off the request; later it uses the latched copy.
   always_comb begin
      eval_cond   = cond_q;
      eval_target = target_q;
      eval_next   = next_q;
      if (state_q == BR_IDLE) begin
         eval_cond   = br_cond;
         eval_target = br_target;
         eval_next   = br_next;
      end
   end

   cond_eval u_cond_eval (
      .cond  (eval_cond),
      .ccr   (ccr_q),
      .taken (eval_taken)
   );

   // Next-state logic: CCR tracking, branch acceptance, the wait-for-flags hold and the response.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      cond_d      = cond_q;
      target_d    = target_q;
      next_d      = next_q;
      res_valid_d = res_valid_q;
      res_taken_d = res_taken_q;
      res_pc_d    = res_pc_q;

      pend_d = setcc;
      ccr_d  = ccr_q;
      if (pend_q) begin
         ccr_d = pack_flags(c_in, z_in, n_in, v_in);
      end

      case (state_q)
         BR_IDLE: begin
            if (accept) begin
               cond_d   = br_cond;
               target_d = br_target;
               next_d   = br_next;
               if (setcc) begin
                  wait_d  = WAIT_SETCC;
                  state_d = BR_HOLD;
               end else if (pend_q) begin
                  wait_d  = WAIT_PEND;
                  state_d = BR_HOLD;
               end else begin
                  res_valid_d = 1'b1;
                  res_taken_d = eval_taken;
                  res_pc_d    = eval_taken ? eval_target : eval_next;
                  state_d     = BR_RESP;
               end
            end
         end
         BR_HOLD: begin
            wait_d = wait_q - 2'd1;
            if (wait_q <= 2'd1) begin
               wait_d      = 2'd0;
               res_valid_d = 1'b1;
               res_taken_d = eval_taken;
               res_pc_d    = eval_taken ? eval_target : eval_next;
               state_d     = BR_RESP;
            end
         end
         BR_RESP: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = BR_IDLE;
            end
         end
         default: begin
            res_valid_d = 1'b0;
            state_d     = BR_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset; reset drops any held branch.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= BR_IDLE;
         wait_q      <= 2'd0;
         pend_q      <= 1'b0;
         ccr_q       <= 4'd0;
         cond_q      <= 4'd0;
         target_q    <= '0;
         next_q      <= '0;
         res_valid_q <= 1'b0;
         res_taken_q <= 1'b0;
         res_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         pend_q      <= pend_d;
         ccr_q       <= ccr_d;
         cond_q      <= cond_d;
         target_q    <= target_d;
         next_q      <= next_d;
         res_valid_q <= res_valid_d;
         res_taken_q <= res_taken_d;
         res_pc_q    <= res_pc_d;
      end
   end

endmodule
